// File: rtl/reg_targetio_router.sv
// Register-bus configured target-IO router: per-pin hi-Z / push-pull / open-drain / static level,
// with a break-before-make guard interval on every mode change and on target power-up.
module reg_targetio_router #(
    parameter int         NUM_IO      = 8,
    parameter logic [5:0] ADDR_MODE   = 6'd40,
    parameter logic [5:0] ADDR_LEVEL  = 6'd41,
    parameter logic [5:0] ADDR_GUARD  = 6'd42,
    parameter logic [5:0] ADDR_STATUS = 6'd43
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic [5:0]        reg_address,
    input  logic [15:0]       reg_bytecnt,
    input  logic [7:0]        reg_datai,
    output logic [7:0]        reg_datao,
    input  logic [15:0]       reg_size,
    input  logic              reg_read,
    input  logic              reg_write,
    input  logic              reg_addrvalid,
    input  logic [5:0]        reg_hypaddress,
    output logic [15:0]       reg_hyplen,
    input  logic [NUM_IO-1:0] src_i,
    input  logic [NUM_IO-1:0] io_in,
    input  logic              target_power_off_i,
    output logic [NUM_IO-1:0] io_out,
    output logic [NUM_IO-1:0] io_oe,
    output logic [NUM_IO-1:0] io_sync_o,
    output logic              busy_o
);

    localparam int MB = (NUM_IO + 3) / 4;
    localparam int IB = (NUM_IO + 7) / 8;

    typedef enum logic {ST_IDLE = 1'b0, ST_GUARD = 1'b1} state_t;

    logic [NUM_IO-1:0][1:0] mode_q, mode_d;
    logic [NUM_IO-1:0]      level_q, level_d;
    logic [7:0]             guard_q, guard_d;
    logic                   pwr_off_q;
    logic                   power_on_edge;
    logic                   wr_en;
    logic [NUM_IO-1:0]      mode_chg;
    logic [NUM_IO-1:0]      oe_next, out_next, busy_next, busy_ch;
    logic [NUM_IO-1:0]      oe_q, out_q, sync1_q, sync2_q;
    logic                   busy_q;
    logic [7:0]             rd_byte, rd_data_q;
    logic                   unused_size;

    assign unused_size   = ^reg_size;
    assign wr_en         = reg_write && reg_addrvalid;
    assign power_on_edge = pwr_off_q && !target_power_off_i;

    // Register file writes; bytes past the register length match no channel and fall away.
    always_comb begin
        mode_d  = mode_q;
        level_d = level_q;
        guard_d = guard_q;
        if (wr_en) begin
            if (reg_address == ADDR_MODE) begin
                for (int n = 0; n < NUM_IO; n++)
                    if (reg_bytecnt == 16'(n / 4)) mode_d[n] = reg_datai[2*(n%4) +: 2];
            end else if (reg_address == ADDR_LEVEL) begin
                for (int n = 0; n < NUM_IO; n++)
                    if (reg_bytecnt == 16'(n / 8)) level_d[n] = reg_datai[n%8];
            end else if (reg_address == ADDR_GUARD) begin
                if (reg_bytecnt == 16'd0) guard_d = reg_datai;
            end
        end
    end

    always_comb begin
        for (int n = 0; n < NUM_IO; n++) mode_chg[n] = (mode_d[n] != mode_q[n]);
    end

    for (genvar gi = 0; gi < NUM_IO; gi++) begin : g_ch
        state_t     state_q, state_d;
        logic [7:0] cnt_q, cnt_d;
        logic       oe_d, out_d;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            oe_d    = 1'b0;
            out_d   = 1'b0;
            if (target_power_off_i) begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end else if (mode_chg[gi] || (power_on_edge && mode_d[gi] != 2'b00)) begin
                if (guard_q == 8'd0) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = ST_GUARD;
                    cnt_d   = guard_q;
                end
            end else if (state_q == ST_GUARD) begin
                // Leaving on the count-of-one edge gives exactly guard_q busy cycles.
                if (cnt_q <= 8'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            if (!target_power_off_i && state_d == ST_IDLE) begin
                unique case (mode_d[gi])
                    2'b00: begin oe_d = 1'b0;          out_d = 1'b0;        end
                    2'b01: begin oe_d = 1'b1;          out_d = src_i[gi];   end
                    2'b10: begin oe_d = ~src_i[gi];    out_d = 1'b0;        end
                    2'b11: begin oe_d = 1'b1;          out_d = level_d[gi]; end
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (reset_i) begin
                state_q <= ST_IDLE;
                cnt_q   <= 8'd0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        assign oe_next[gi]   = oe_d;
        assign out_next[gi]  = out_d;
        assign busy_next[gi] = (state_d == ST_GUARD);
        assign busy_ch[gi]   = (state_q == ST_GUARD);
    end

    always_comb begin
        rd_byte = 8'h00;
        if (reg_read && reg_addrvalid) begin
            case (reg_address)
                ADDR_MODE: begin
                    for (int n = 0; n < NUM_IO; n++)
                        if (reg_bytecnt == 16'(n / 4)) rd_byte[2*(n%4) +: 2] = mode_q[n];
                end
                ADDR_LEVEL: begin
                    for (int n = 0; n < NUM_IO; n++)
                        if (reg_bytecnt == 16'(n / 8)) rd_byte[n%8] = level_q[n];
                end
                ADDR_GUARD: begin
                    if (reg_bytecnt == 16'd0) rd_byte = guard_q;
                end
                ADDR_STATUS: begin
                    for (int n = 0; n < NUM_IO; n++) begin
                        if (reg_bytecnt == 16'(n / 8))      rd_byte[n%8] = sync2_q[n];
                        if (reg_bytecnt == 16'(IB + n / 8)) rd_byte[n%8] = busy_ch[n];
                    end
                end
                default: rd_byte = 8'h00;
            endcase
        end
    end

    always_comb begin
        case (reg_hypaddress)
            ADDR_MODE:   reg_hyplen = 16'(MB);
            ADDR_LEVEL:  reg_hyplen = 16'(IB);
            ADDR_GUARD:  reg_hyplen = 16'd1;
            ADDR_STATUS: reg_hyplen = 16'(2 * IB);
            default:     reg_hyplen = 16'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            mode_q    <= '0;
            level_q   <= '0;
            guard_q   <= 8'd10;
            pwr_off_q <= 1'b0;
            oe_q      <= '0;
            out_q     <= '0;
            busy_q    <= 1'b0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            rd_data_q <= 8'h00;
        end else begin
            mode_q    <= mode_d;
            level_q   <= level_d;
            guard_q   <= guard_d;
            pwr_off_q <= target_power_off_i;
            oe_q      <= oe_next;
            out_q     <= out_next;
            busy_q    <= |busy_next;
            sync1_q   <= io_in;
            sync2_q   <= sync1_q;
            rd_data_q <= rd_byte;
        end
    end

    assign io_oe     = oe_q;
    assign io_out    = out_q;
    assign busy_o    = busy_q;
    assign io_sync_o = sync2_q;
    assign reg_datao = rd_data_q;

endmodule

// File: tb/tb_reg_targetio_router.sv
// Self-checking bench for reg_targetio_router: mode vector table, read scoreboard,
// and hand-written guard / power / synchroniser / reset sequences.
module tb_reg_targetio_router;

    localparam logic [5:0] A_MODE = 6'd40, A_LEVEL = 6'd41, A_GUARD = 6'd42, A_STATUS = 6'd43;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [5:0]  reg_address = '0;
    logic [15:0] reg_bytecnt = '0;
    logic [7:0]  reg_datai = '0;
    logic [7:0]  reg_datao;
    logic [15:0] reg_size = 16'd1;
    logic        reg_read = 1'b0, reg_write = 1'b0, reg_addrvalid = 1'b0;
    logic [5:0]  reg_hypaddress = '0;
    logic [15:0] reg_hyplen;
    logic [7:0]  src_i = '0, io_in = '0;
    logic        target_power_off_i = 1'b0;
    logic [7:0]  io_out, io_oe, io_sync_o;
    logic        busy_o;

    reg_targetio_router dut (
        .clk(clk), .reset_i(reset_i), .reg_address(reg_address), .reg_bytecnt(reg_bytecnt),
        .reg_datai(reg_datai), .reg_datao(reg_datao), .reg_size(reg_size), .reg_read(reg_read),
        .reg_write(reg_write), .reg_addrvalid(reg_addrvalid), .reg_hypaddress(reg_hypaddress),
        .reg_hyplen(reg_hyplen), .src_i(src_i), .io_in(io_in),
        .target_power_off_i(target_power_off_i), .io_out(io_out), .io_oe(io_oe),
        .io_sync_o(io_sync_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } rd_exp_t;
    rd_exp_t sb[$];

    typedef struct {
        logic [7:0] mode0, mode1, src, level, exp_oe, exp_out;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [15:0] b, input logic [7:0] d);
        reg_address = a; reg_bytecnt = b; reg_datai = d;
        reg_write = 1'b1; reg_addrvalid = 1'b1;
        tick();
        reg_write = 1'b0; reg_addrvalid = 1'b0;
    endtask

    task automatic rd(input string name, input logic [5:0] a, input logic [15:0] b,
                      input logic [7:0] exp);
        rd_exp_t e;
        e.name = name; e.exp = exp;
        sb.push_back(e);
        reg_address = a; reg_bytecnt = b;
        reg_read = 1'b1; reg_addrvalid = 1'b1;
        tick();
        reg_read = 1'b0; reg_addrvalid = 1'b0;
    endtask

    // Read monitor: each accepted read strobe yields reg_datao one edge later.
    initial begin
        rd_exp_t e;
        forever begin
            @(posedge clk);
            if (reg_read && reg_addrvalid) begin
                #1;
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_empty: got read data %0h with no expectation queued", reg_datao);
                end else begin
                    e = sb.pop_front();
                    chk(e.name, 32'(reg_datao), 32'(e.exp));
                end
            end
        end
    end

    initial begin
        logic [5:0]  hyp_addr[5];
        logic [15:0] hyp_len[5];

        // mode0 ch0..3 (ch0 in [1:0]), mode1 ch4..7
        vecs[0] = '{8'hE4, 8'h00, 8'h0F, 8'h08, 8'h0A, 8'h0A};
        vecs[1] = '{8'hE4, 8'h00, 8'h00, 8'h00, 8'h0E, 8'h00};
        vecs[2] = '{8'h55, 8'h00, 8'h05, 8'h00, 8'h0F, 8'h05};
        vecs[3] = '{8'hAA, 8'h00, 8'h05, 8'h00, 8'h0A, 8'h00};
        vecs[4] = '{8'hFF, 8'h00, 8'hFF, 8'h06, 8'h0F, 8'h06};
        vecs[5] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00};
        vecs[6] = '{8'h00, 8'h1B, 8'h60, 8'h10, 8'h50, 8'h50};
        hyp_addr = '{A_MODE, A_LEVEL, A_GUARD, A_STATUS, 6'd10};
        hyp_len  = '{16'd2, 16'd1, 16'd1, 16'd2, 16'd0};

        // Reset state
        repeat (3) tick();
        reset_i = 1'b0;
        chk("rst_oe", 32'(io_oe), 32'h0);
        chk("rst_out", 32'(io_out), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_sync", 32'(io_sync_o), 32'h0);
        chk("rst_datao", 32'(reg_datao), 32'h0);
        rd("rst_guard_rd", A_GUARD, 16'd0, 8'h0A);
        rd("unowned_rd", 6'd10, 16'd0, 8'h00);
        rd("mode_byte_oob_rd", A_MODE, 16'd2, 8'h00);
        for (int i = 0; i < 5; i++) begin
            reg_hypaddress = hyp_addr[i];
            #1;
            chk($sformatf("hyplen_%0d", hyp_addr[i]), 32'(reg_hyplen), 32'(hyp_len[i]));
        end

        // Guard of 3 on ch0 push-pull
        src_i = 8'h01;
        wr(A_GUARD, 16'd0, 8'd3);
        rd("guard3_rd", A_GUARD, 16'd0, 8'd3);
        wr(A_MODE, 16'd0, 8'h01);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("g3_busy_%0d", i), 32'(busy_o), 32'h1);
            chk($sformatf("g3_oe_%0d", i), 32'(io_oe), 32'h0);
            tick();
        end
        chk("g3_done_busy", 32'(busy_o), 32'h0);
        chk("g3_done_oe", 32'(io_oe), 32'h01);
        chk("g3_done_out", 32'(io_out), 32'h01);
        src_i = 8'h00;
        tick();
        chk("g3_follow_out", 32'(io_out), 32'h00);
        chk("g3_follow_oe", 32'(io_oe), 32'h01);

        // Open drain on ch2 with zero guard
        wr(A_GUARD, 16'd0, 8'd0);
        wr(A_MODE, 16'd0, 8'h20);
        chk("od_low_oe", 32'(io_oe), 32'h04);
        chk("od_low_out", 32'(io_out), 32'h00);
        chk("od_busy", 32'(busy_o), 32'h0);
        src_i = 8'h04;
        tick();
        chk("od_high_oe", 32'(io_oe), 32'h00);
        wr(A_GUARD, 16'd0, 8'd3);
        wr(A_MODE, 16'd0, 8'h20);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("same_mode_busy_%0d", i), 32'(busy_o), 32'h0);
            tick();
        end

        // Second mode write mid-guard reloads; newest mode wins
        wr(A_LEVEL, 16'd0, 8'h01);
        wr(A_GUARD, 16'd0, 8'd5);
        wr(A_MODE, 16'd0, 8'h21);
        chk("g5_first_busy", 32'(busy_o), 32'h1);
        chk("g5_first_oe0", 32'(io_oe[0]), 32'h0);
        tick();
        chk("g5_mid_oe0", 32'(io_oe[0]), 32'h0);
        wr(A_MODE, 16'd0, 8'h23);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("g5_busy_%0d", i), 32'(busy_o), 32'h1);
            chk($sformatf("g5_oe0_%0d", i), 32'(io_oe[0]), 32'h0);
            tick();
        end
        chk("g5_final_busy", 32'(busy_o), 32'h0);
        chk("g5_final_oe0", 32'(io_oe[0]), 32'h1);
        chk("g5_final_out0", 32'(io_out[0]), 32'h1);

        // Steady-state mode table with zero guard
        wr(A_GUARD, 16'd0, 8'd0);
        for (int v = 0; v < 7; v++) begin
            src_i = vecs[v].src;
            wr(A_LEVEL, 16'd0, vecs[v].level);
            wr(A_MODE, 16'd1, vecs[v].mode1);
            wr(A_MODE, 16'd0, vecs[v].mode0);
            tick();
            chk($sformatf("vec%0d_oe", v), 32'(io_oe), 32'(vecs[v].exp_oe));
            chk($sformatf("vec%0d_out", v), 32'(io_out), 32'(vecs[v].exp_out));
            chk($sformatf("vec%0d_busy", v), 32'(busy_o), 32'h0);
            rd($sformatf("vec%0d_mode_rd", v), A_MODE, 16'd0, vecs[v].mode0);
        end

        // Power off / on
        wr(A_MODE, 16'd1, 8'h00);
        wr(A_MODE, 16'd0, 8'h55);
        src_i = 8'h0F;
        tick();
        chk("pwr_pre_oe", 32'(io_oe), 32'h0F);
        wr(A_GUARD, 16'd0, 8'd4);
        target_power_off_i = 1'b1;
        tick();
        chk("pwr_off_oe", 32'(io_oe), 32'h00);
        chk("pwr_off_out", 32'(io_out), 32'h00);
        tick();
        chk("pwr_off_busy", 32'(busy_o), 32'h0);
        target_power_off_i = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                rd_exp_t e;
                e.name = "pwr_status_busy_rd"; e.exp = 8'h0F;
                sb.push_back(e);
                reg_address = A_STATUS; reg_bytecnt = 16'd1;
                reg_read = 1'b1; reg_addrvalid = 1'b1;
            end
            chk($sformatf("pwr_on_busy_%0d", i), 32'(busy_o), 32'h1);
            chk($sformatf("pwr_on_oe_%0d", i), 32'(io_oe), 32'h00);
            tick();
            reg_read = 1'b0; reg_addrvalid = 1'b0;
        end
        chk("pwr_restored_oe", 32'(io_oe), 32'h0F);
        chk("pwr_restored_out", 32'(io_out), 32'h0F);
        chk("pwr_restored_busy", 32'(busy_o), 32'h0);

        // Input synchroniser and STATUS
        io_in = 8'hA5;
        tick();
        chk("sync_1cyc", 32'(io_sync_o), 32'h00);
        tick();
        chk("sync_2cyc", 32'(io_sync_o), 32'hA5);
        rd("status_in_rd", A_STATUS, 16'd0, 8'hA5);
        rd("status_busy_idle_rd", A_STATUS, 16'd1, 8'h00);

        // Reset in the middle of a guard
        wr(A_GUARD, 16'd0, 8'd5);
        wr(A_MODE, 16'd0, 8'h00);
        chk("rstg_busy_before", 32'(busy_o), 32'h1);
        reset_i = 1'b1;
        tick();
        chk("rstg_oe", 32'(io_oe), 32'h00);
        chk("rstg_busy", 32'(busy_o), 32'h0);
        reset_i = 1'b0;
        tick();
        chk("rstg_oe_after", 32'(io_oe), 32'h00);
        rd("rstg_guard_rd", A_GUARD, 16'd0, 8'h0A);
        rd("rstg_mode_rd", A_MODE, 16'd0, 8'h00);

        tick();
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
